disp_strip_sequencer: RTL and testbench
=======================================

Name: disp_strip_sequencer

Overview:
Upstream and downstream companion of the disparity engine, compute_max_disp. It accepts a raster-order stream of left/right pixel pairs and builds a sliding WIN-row strip for each image. For every valid window column it drives the engine's strip, col_index and input_ready, waits for done, and forwards the disparity over a valid/ready output. It also restarts the engine between columns.

Parameters:
WIN, 15, window edge length (rows per strip)
DATA_SIZE, 8, bits per pixel
IMG_W, 64, pixels per image row
IMG_H, 48, rows per frame
MAX_DISP, 64, disparity range; DISP_BITS = clog2(MAX_DISP)
TIMEOUT, 4096, engine watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pix_valid  in  1  pixel pair valid
pix_ready  out  1  pixel pair accepted when pix_valid and pix_ready are both high
pix_L  in  DATA_SIZE  left pixel
pix_R  in  DATA_SIZE  right pixel
strip_L  out  DATA_SIZE*IMG_W*WIN  left strip to engine input_array_L
strip_R  out  DATA_SIZE*IMG_W*WIN  right strip to engine input_array_R
col_index  out  clog2(IMG_W)  window start column to engine
input_ready  out  1  engine start pulse
eng_rst  out  1  active-high engine restart pulse
eng_done  in  1  engine done
eng_disp  in  DISP_BITS  engine output_disp
disp_valid  out  1  disparity available
disp_ready  in  1  downstream accepts disparity
disp_out  out  DISP_BITS  disparity value
disp_col  out  clog2(IMG_W)  column of disp_out
disp_row  out  clog2(IMG_H)  centre-less row tag: index of the newest row in the strip
frame_done  out  1  one-cycle pulse after the last disparity of a frame is accepted

Behaviour:
- Reset (rst low, asynchronous) clears everything:
  - all outputs 0; strips all-zero; state FILL.
  - row counter, fill counter and column counter all 0.
  - A reset mid-operation aborts any engine wait. Partial rows are discarded.
- Storage: one incoming-row buffer (IMG_W pixels) per image, plus WIN strip rows per image.
  - Strip element k = row r*IMG_W + c. Row 0 is the oldest row, row WIN-1 the newest.
- FILL:
  - pix_ready = 1; one pair is accepted per handshake cycle into incoming[wcol], and wcol increments.
  - On the IMG_W-th accept, all strip rows shift down one (row 0 is dropped) and the incoming row becomes row WIN-1, in the same edge.
  - wcol returns to 0; rows_filled increments, saturating at WIN; row_cnt increments.
  - If rows_filled (after the update) < WIN, stay in FILL. Otherwise go to ISSUE with col = 0.
- ISSUE:
  - pix_ready = 0; input_ready = 1 for exactly one cycle; col_index = col.
  - Then go to WAIT.
- WAIT:
  - Sample eng_done only in this state; eng_done in any other state is ignored.
  - On eng_done: latch eng_disp into disp_out, set disp_col = col and disp_row = row_cnt-1, assert disp_valid, and go to EMIT.
- EMIT:
  - disp_valid held with disp_out, disp_col and disp_row stable until disp_ready is high.
  - On the handshake: eng_rst = 1 for one cycle and disp_valid drops.
  - If col < IMG_W-WIN: col increments, go to ISSUE.
  - Otherwise col = 0. If row_cnt == IMG_H, pulse frame_done, clear row_cnt and rows_filled, and go to FILL. Otherwise go to FILL (next row).
- Strip stability: strip_L, strip_R and col_index do not change from ISSUE through EMIT.
- Latency:
  - The first input_ready comes 1 cycle after the WIN*IMG_W-th accepted pixel.
  - disp_valid rises 1 cycle after eng_done.
  - The next input_ready comes 2 cycles after the disp handshake (eng_rst cycle, then ISSUE).
- Ready: pix_ready is never high outside FILL.
- Simultaneous events: disp_ready already high when disp_valid rises completes the handshake in that first EMIT cycle.

Optional Feature:
DSS_ENGINE_TIMEOUT_EN.
- Defined:
  - Adds an output eng_timeout (1 bit, sticky until reset) and a WAIT-state counter.
  - If TIMEOUT cycles elapse in WAIT without eng_done: disp_out = 0, disp_valid = 1, eng_timeout = 1, go to EMIT. The normal eng_rst follows the handshake.
- Undefined: no port and no counter; WAIT lasts indefinitely.

Test Plan:
- Reset hold, then stream WIN*IMG_W = 960 pairs with pix_valid always high -> pix_ready low on the cycle after pair 960; input_ready one-cycle pulse with col_index = 0; strip row 14 equals the last 64 pixels streamed.
- Engine model returns eng_disp = 5 after 20 cycles; disp_ready held high -> disp_valid with disp_out = 5, disp_col = 0, disp_row = 14; eng_rst pulse; input_ready with col_index = 1 two cycles later; 50 disparities total, last with disp_col = 49, then pix_ready high.
- disp_ready held low for 10 cycles in EMIT -> disp_out/disp_col stable for all 10; no eng_rst and no new input_ready until the handshake.
- Stream a full 64x48 frame -> 34 rows x 50 = 1700 disparities; frame_done pulses once, after disparity (row 47, col 49); the next frame needs 960 fresh pixels before its first input_ready.
- Assert rst low mid-WAIT -> all outputs 0 immediately, asynchronously; after release, a full 960 pixels are required before input_ready.
- With DSS_ENGINE_TIMEOUT_EN and TIMEOUT = 4096, the engine never asserts done -> after 4096 WAIT cycles, disp_valid with disp_out = 0 and eng_timeout = 1; a stray eng_done during FILL has no effect.

Source files
------------

// File: rtl/disp_strip_sequencer.sv
// disp_strip_sequencer: builds sliding WIN-row strips from a raster pixel stream and sequences compute_max_disp per column.
// Define DSS_ENGINE_TIMEOUT_EN to add the WAIT watchdog and the sticky eng_timeout output.
module disp_strip_sequencer #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 48,
  parameter int MAX_DISP  = 64,
  parameter int TIMEOUT   = 4096
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  input  logic [DATA_SIZE-1:0]                pix_L,
  input  logic [DATA_SIZE-1:0]                pix_R,
  output logic [DATA_SIZE*IMG_W*WIN-1:0]      strip_L,
  output logic [DATA_SIZE*IMG_W*WIN-1:0]      strip_R,
  output logic [$clog2(IMG_W)-1:0]            col_index,
  output logic                                input_ready,
  output logic                                eng_rst,
  input  logic                                eng_done,
  input  logic [$clog2(MAX_DISP)-1:0]         eng_disp,
  output logic                                disp_valid,
  input  logic                                disp_ready,
  output logic [$clog2(MAX_DISP)-1:0]         disp_out,
  output logic [$clog2(IMG_W)-1:0]            disp_col,
  output logic [$clog2(IMG_H)-1:0]            disp_row,
  output logic                                frame_done
`ifdef DSS_ENGINE_TIMEOUT_EN
  ,
  output logic                                eng_timeout
`endif
);
  localparam int ROWB = DATA_SIZE*IMG_W;
  localparam int STRB = ROWB*WIN;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int NW   = $clog2(IMG_H+1);
  localparam int FW   = $clog2(WIN+1);
  localparam int DB   = $clog2(MAX_DISP);
  typedef enum logic [2:0] {S_FILL, S_ISSUE, S_WAIT, S_EMIT, S_RESTART} state_t;
  state_t          r_state, w_next;
  logic [ROWB-1:0] r_inc_L, r_inc_R;
  logic [STRB-1:0] r_strip_L, r_strip_R;
  logic [CW-1:0]   r_wcol, r_col, r_disp_col;
  logic [FW-1:0]   r_rows_filled;
  logic [NW-1:0]   r_row_cnt;
  logic [DB-1:0]   r_disp;
  logic [RW-1:0]   r_disp_row;
  logic            r_pix_ready;
  logic            w_accept, w_row_end, w_last_col, w_frame_end, w_capture, w_to;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_FILL;
    else r_state <= w_next;
  always_comb begin
    w_next      = r_state;
    w_accept    = pix_valid && r_pix_ready;
    w_row_end   = w_accept && (r_wcol == CW'(IMG_W-1));
    w_last_col  = r_col == CW'(IMG_W-WIN);
    w_frame_end = r_row_cnt == NW'(IMG_H);
    w_capture   = (r_state == S_WAIT) && (eng_done || w_to);
    input_ready = r_state == S_ISSUE;
    eng_rst     = r_state == S_RESTART;
    disp_valid  = r_state == S_EMIT;
    frame_done  = eng_rst && w_last_col && w_frame_end;
    case (r_state)
      S_FILL:    if (w_row_end && r_rows_filled >= FW'(WIN-1)) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (w_capture) w_next = S_EMIT;
      S_EMIT:    if (disp_ready) w_next = S_RESTART;
      S_RESTART: w_next = w_last_col ? S_FILL : S_ISSUE;
      default:   w_next = S_FILL;
    endcase
  end
  // Newest row enters at the top of the strip; row 0 (oldest) falls off the bottom.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix_ready   <= 1'b0;
      r_inc_L       <= '0;
      r_inc_R       <= '0;
      r_strip_L     <= '0;
      r_strip_R     <= '0;
      r_wcol        <= '0;
      r_col         <= '0;
      r_rows_filled <= '0;
      r_row_cnt     <= '0;
      r_disp        <= '0;
      r_disp_col    <= '0;
      r_disp_row    <= '0;
    end else begin
      r_pix_ready <= w_next == S_FILL;
      if (w_accept) begin
        r_inc_L[r_wcol*DATA_SIZE +: DATA_SIZE] <= pix_L;
        r_inc_R[r_wcol*DATA_SIZE +: DATA_SIZE] <= pix_R;
        r_wcol <= w_row_end ? '0 : r_wcol + CW'(1);
      end
      if (w_row_end) begin
        r_strip_L     <= {pix_L, r_inc_L[ROWB-DATA_SIZE-1:0], r_strip_L[STRB-1:ROWB]};
        r_strip_R     <= {pix_R, r_inc_R[ROWB-DATA_SIZE-1:0], r_strip_R[STRB-1:ROWB]};
        r_rows_filled <= (r_rows_filled == FW'(WIN)) ? r_rows_filled : r_rows_filled + FW'(1);
        r_row_cnt     <= r_row_cnt + NW'(1);
      end
      if (w_capture) begin
        r_disp     <= eng_done ? eng_disp : '0;
        r_disp_col <= r_col;
        r_disp_row <= RW'(r_row_cnt - NW'(1));
      end
      if (r_state == S_RESTART) begin
        r_col <= w_last_col ? '0 : r_col + CW'(1);
        if (w_last_col && w_frame_end) begin
          r_row_cnt     <= '0;
          r_rows_filled <= '0;
        end
      end
    end
  end
`ifdef DSS_ENGINE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] r_to_cnt;
  logic          r_eng_timeout;
  assign w_to        = (r_state == S_WAIT) && (r_to_cnt == TW'(TIMEOUT-1));
  assign eng_timeout = r_eng_timeout;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt      <= '0;
      r_eng_timeout <= 1'b0;
    end else begin
      r_to_cnt      <= (r_state == S_WAIT) ? r_to_cnt + TW'(1) : '0;
      r_eng_timeout <= r_eng_timeout || (w_to && !eng_done);
    end
  end
`else
  assign w_to = 1'b0;
`endif
  assign pix_ready = r_pix_ready;
  assign strip_L   = r_strip_L;
  assign strip_R   = r_strip_R;
  assign col_index = r_col;
  assign disp_out  = r_disp;
  assign disp_col  = r_disp_col;
  assign disp_row  = r_disp_row;
endmodule

// File: tb/tb_disp_strip_sequencer.sv
// tb_disp_strip_sequencer: random pixel stream, random-latency engine and random backpressure against a frame-level model.
module tb_disp_strip_sequencer;
  localparam int WIN  = 15;
  localparam int DSZ  = 8;
  localparam int IMG_W = 64;
  localparam int IMG_H = 48;
  localparam int STRB = DSZ*IMG_W*WIN;
  localparam int CAP  = 80000;
  logic            clk = 1'b0;
  logic            rst, pix_valid, pix_ready, input_ready, eng_rst, eng_done;
  logic            disp_valid, disp_ready, frame_done;
  logic [DSZ-1:0]  pix_L, pix_R;
  logic [STRB-1:0] strip_L, strip_R;
  logic [5:0]      col_index, eng_disp, disp_out, disp_col, disp_row;
`ifdef DSS_ENGINE_TIMEOUT_EN
  logic            eng_timeout;
`endif
  logic [DSZ-1:0]  img_L [IMG_H][IMG_W];
  logic [DSZ-1:0]  img_R [IMG_H][IMG_W];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int p, exp_row, exp_col, exp_disp, lat, dv_age, n_disp = 0, frames = 0, n0;
  int ir_due = -1, rst_due = -1, fd_due = -1, pr_due = -1;
  bit busy, dv;
  disp_strip_sequencer dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_L(pix_L), .pix_R(pix_R), .strip_L(strip_L), .strip_R(strip_R),
    .col_index(col_index), .input_ready(input_ready), .eng_rst(eng_rst),
    .eng_done(eng_done), .eng_disp(eng_disp), .disp_valid(disp_valid),
    .disp_ready(disp_ready), .disp_out(disp_out), .disp_col(disp_col),
    .disp_row(disp_row), .frame_done(frame_done)
`ifdef DSS_ENGINE_TIMEOUT_EN
    , .eng_timeout(eng_timeout)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask
  // Number of strip pixels that differ from image rows newest-WIN+1 .. newest.
  function automatic int strip_bad(input logic [STRB-1:0] s, input int newest, input bit right);
    int bad = 0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++)
        if (s[(r*IMG_W+c)*DSZ +: DSZ] !== (right ? img_R[newest-WIN+1+r][c] : img_L[newest-WIN+1+r][c])) bad++;
    return bad;
  endfunction
  task automatic new_frame();
    p = 0;
    exp_row = WIN-1;
    exp_col = 0;
    foreach (img_L[r, c]) begin
      img_L[r][c] = DSZ'($urandom);
      img_R[r][c] = DSZ'($urandom);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    pix_valid = 1'b0;
    eng_done = 1'b0;
    disp_ready = 1'b0;
    #1;
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_input_ready", input_ready, 0);
    chk("rst_eng_rst", eng_rst, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_disp_out", disp_out, 0);
    chk("rst_disp_col", disp_col, 0);
    chk("rst_disp_row", disp_row, 0);
    chk("rst_col_index", col_index, 0);
    chk("rst_strip_L_nonzero", strip_L != '0, 0);
    chk("rst_strip_R_nonzero", strip_R != '0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    busy = 0;
    dv = 0;
    dv_age = 0;
    ir_due = -1;
    rst_due = -1;
    fd_due = -1;
    pr_due = cyc + 1;
    new_frame();
  endtask
  // One cycle: check this cycle's outputs against the model, then drive inputs for the coming edge.
  task automatic step();
    bit hs, got_done;
    @(negedge clk);
    cyc++;
    chk("input_ready", input_ready, cyc == ir_due);
    chk("eng_rst", eng_rst, cyc == rst_due);
    chk("frame_done", frame_done, cyc == fd_due);
    chk("disp_valid", disp_valid, dv);
`ifdef DSS_ENGINE_TIMEOUT_EN
    chk("eng_timeout", eng_timeout, 0);
`endif
    if (cyc == pr_due) chk("pix_ready_on", pix_ready, 1);
    if (input_ready || eng_rst || dv) chk("pix_ready_off", pix_ready, 0);
    if (dv) begin
      chk("disp_out", disp_out, exp_disp);
      chk("disp_col", disp_col, exp_col);
      chk("disp_row", disp_row, exp_row);
    end
    if (input_ready) begin
      chk("col_index", col_index, exp_col);
      chk("pixels_before_issue", p, (exp_row+1)*IMG_W);
      chk("strip_L_bad_px", strip_bad(strip_L, exp_row, 0), 0);
      chk("strip_R_bad_px", strip_bad(strip_R, exp_row, 1), 0);
      busy = 1;
      lat = $urandom_range(10, 2);
    end
    got_done = 0;
    eng_done = 1'b0;
    if (busy) begin
      lat--;
      if (lat == 0) begin
        busy = 0;
        got_done = 1;
        eng_done = 1'b1;
        eng_disp = 6'($urandom);
        exp_disp = eng_disp;
      end
    end else if (!dv && $urandom_range(15, 0) == 0) begin
      eng_done = 1'b1;
      eng_disp = 6'($urandom);
    end
    disp_ready = (n_disp == 0) ? (dv_age >= 10) : ($urandom_range(3, 0) != 0);
    hs = dv && disp_ready;
    if (hs) begin
      chk("col_index_hold", col_index, exp_col);
      chk("strip_L_hold_bad_px", strip_bad(strip_L, exp_row, 0), 0);
      rst_due = cyc + 1;
      n_disp++;
      dv = 0;
      dv_age = 0;
      if (exp_col == IMG_W-WIN) begin
        exp_col = 0;
        pr_due = cyc + 2;
        exp_row++;
        if (exp_row == IMG_H) begin
          fd_due = cyc + 1;
          frames++;
          new_frame();
        end
      end else begin
        exp_col++;
        ir_due = cyc + 2;
      end
    end else if (dv) dv_age++;
    if (got_done) dv = 1;
    pix_valid = (p < IMG_W*IMG_H) && ($urandom_range(3, 0) != 0);
    if (pix_valid) begin
      pix_L = img_L[p/IMG_W][p%IMG_W];
      pix_R = img_R[p/IMG_W][p%IMG_W];
    end
    if (pix_valid && pix_ready) begin
      p++;
      if (p % IMG_W == 0 && p/IMG_W >= WIN) ir_due = cyc + 1;
    end
  endtask
  initial begin
    rst = 1'b0;
    pix_valid = 1'b0;
    pix_L = '0;
    pix_R = '0;
    eng_done = 1'b0;
    eng_disp = '0;
    disp_ready = 1'b0;
    do_reset();
    while (frames < 1 && cyc < CAP) step();
    while (!(frames == 1 && busy && !input_ready && lat >= 3 && exp_row == WIN) && cyc < CAP) step();
    #2;
    do_reset();
    n0 = n_disp;
    while (n_disp < n0 + 60 && cyc < CAP) step();
    chk("cycle_budget", cyc < CAP, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
